rv_wb_lsu: RTL and testbench
============================

RV_WB_LSU -- requirements
Module: rv_wb_lsu

Interface
REQ-001 The block SHALL have these parameters: WBUF_DEPTH, 4, posted-write FIFO depth (power of two, 2..16); SEL_MSB, 31, top address bit of the slave-select field; SEL_LSB, 28, bottom address bit of the slave-select field; TCM_SEL, 4'h0, select value that marks the TCM; TIMEOUT_CYCLES, 255, bus-cycle limit when timeout is compiled in.
REQ-002 The block SHALL use one clock, i_clk, and an asynchronous active-low reset, i_reset_n.
REQ-003 The block SHALL have these ports:
- i_clk  in  1  clock
- i_reset_n  in  1  async active-low reset
- i_req  in  1  memory-stage access valid
- i_we  in  1  store (1) / load (0)
- i_addr  in  32  byte address
- i_wdata  in  32  store data, unaligned (bits [7:0]/[15:0]/[31:0])
- i_funct3  in  3  RV32 width/sign code
- o_stall  out  1  hold memory stage
- o_rdata  out  32  aligned, extended load data
- o_rvalid  out  1  load data valid, one-cycle pulse
- o_err  out  1  misaligned/bus error/timeout, one-cycle pulse
- o_tcm_hit  out  1  access targets TCM; no bus cycle issued
- o_wb_adr  out  32  word address, [1:0]=0
- o_wb_dat  out  32  lane-positioned write data
- i_wb_dat  in  32  read data
- o_wb_we  out  1  write enable
- o_wb_sel  out  4  byte lanes
- o_wb_stb  out  1  strobe
- o_wb_cyc  out  1  cycle
- i_wb_ack  in  1  acknowledge
- i_wb_err  in  1  bus error

Function
REQ-004 A request SHALL be accepted in a cycle with i_req=1 and o_stall=0.
REQ-005 o_tcm_hit SHALL be i_req & (i_addr[SEL_MSB:SEL_LSB]==TCM_SEL), combinational; TCM requests SHALL NOT enter the FIFO, start a bus cycle, or stall.
REQ-006 Misalignment (halfword with addr[0]=1; word with addr[1:0]!=0) SHALL raise o_err for one cycle after acceptance and SHALL NOT start a bus cycle.
REQ-007 Byte lanes: SB sel=4'b0001<<addr[1:0], data byte replicated x4; SH sel=4'b0011<<{addr[1],1'b0}, data halfword replicated x2; SW sel=4'b1111.
REQ-008 A store SHALL push {adr,dat,sel} into the FIFO on acceptance; o_stall for a store SHALL be i_req & i_we & full, where full is derived from the registered count only (a pop in the same cycle does not free a slot).
REQ-009 The FSM SHALL have states IDLE, WRITE, READ; IDLE->WRITE when the FIFO is non-empty; WRITE->IDLE/WRITE on ack or err (pop head); IDLE->READ when a load is pending and the FIFO is empty; READ->IDLE on ack or err.
REQ-010 A load SHALL NOT issue until all previously posted writes have completed, preserving program order.
REQ-011 o_stall for a load SHALL be high from its first presented cycle until o_rvalid=1; in the o_rvalid cycle o_stall SHALL be 0.
REQ-012 stb/cyc SHALL assert the cycle after entering WRITE/READ and hold with stable adr/dat/sel/we until ack or err.
REQ-013 On a read ack, the next cycle SHALL register o_rvalid=1 with o_rdata: LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged, lane picked by addr[1:0].
REQ-014 i_wb_err SHALL end the cycle like ack and pulse o_err; a read so ended SHALL also pulse o_rvalid with o_rdata=0.
REQ-015 Minimum load latency SHALL be 3 cycles, from acceptance to o_rvalid, with ack on the first stb cycle.

Reset
REQ-016 Reset assertion SHALL force IDLE, FIFO empty, and every output to 0 except o_tcm_hit, which remains combinational; an in-flight cycle and buffered writes SHALL be discarded.
REQ-017 The first acceptance SHALL occur no earlier than the first rising edge after i_reset_n deasserts.

Configuration
REQ-018 With LSU_TIMEOUT_EN defined, a counter SHALL count stb-high cycles; reaching TIMEOUT_CYCLES without ack or err SHALL end the cycle as an err (REQ-014), and the counter SHALL clear at each new cycle.
REQ-019 Without LSU_TIMEOUT_EN, no counter SHALL exist and bus cycles SHALL wait indefinitely.

Verification
REQ-020 The bench SHALL cover these scenarios:
- SB 0xA5 to 0x1000_0003 -> sel=1000, dat=A5A5A5A5, adr=0x1000_0000, no stall.
- LH from 0x1000_0002, bus data 0x8001_0000 -> o_rdata=0xFFFF_8001; LHU -> 0x0000_8001; rvalid 3 cycles after acceptance with immediate ack.
- WBUF_DEPTH=4, ack held low, 5 stores -> 5th stalls; one ack -> 5th accepted the following cycle; writes complete in order.
- 2 stores pending then a load -> load stb only after the 2nd write ack.
- LW at 0x1000_0002 -> o_err pulse, no cyc; i_wb_err on a read -> o_err and o_rvalid with rdata=0.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8, no ack -> stb drops after 8 cycles with an o_err pulse; reset mid-read -> all outputs 0 and FIFO empty.

Source files
------------

// File: rtl/rv_wb_lsu.sv
// RV32 load/store unit: TCM decode, posted-write FIFO and a single Wishbone master port.
// Optional bus-cycle timeout is compiled in when LSU_TIMEOUT_EN is defined.
module rv_wb_lsu #(
  parameter int WBUF_DEPTH = 4,
  parameter int SEL_MSB = 31,
  parameter int SEL_LSB = 28,
  parameter logic [SEL_MSB-SEL_LSB:0] TCM_SEL = 4'h0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_err,
  output logic        o_tcm_hit,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);
  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state;

  logic [31:0]   adr_mem [WBUF_DEPTH];
  logic [31:0]   dat_mem [WBUF_DEPTH];
  logic [3:0]    sel_mem [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          load_busy;
  logic [31:0]   ld_addr;
  logic [2:0]    ld_f3;

  logic        misaligned, lsu_req, full, load_wait, load_start, push, pop, err_accept;
  logic        bus_err, bus_done;
  logic [3:0]  st_sel;
  logic [31:0] st_dat;

  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   lane_sel = 4'b0001 << a;
      2'b01:   lane_sel = 4'b0011 << {a[1], 1'b0};
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'h0, b};
      3'b101:  load_ext = {16'h0, h};
      default: load_ext = d;
    endcase
  endfunction

  assign o_tcm_hit  = i_req & (i_addr[SEL_MSB:SEL_LSB] == TCM_SEL);
  assign misaligned = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                      (i_funct3[1] && i_addr[1:0] != 2'b00);
  assign lsu_req    = i_req & ~o_tcm_hit;
  assign full       = (count == FULL_CNT);
  // A load is held in the stage until its data returns; the o_rvalid cycle releases it
  // and must not be mistaken for a fresh load.
  assign load_wait  = lsu_req & ~i_we & ~misaligned & ~o_rvalid;
  assign load_start = load_wait & ~load_busy;
  assign o_stall    = i_reset_n & ((lsu_req & i_we & full) | load_wait);
  assign push       = lsu_req & i_we & ~misaligned & ~full;
  assign err_accept = lsu_req & misaligned & ~o_stall;

  always_comb begin
    st_sel = lane_sel(i_funct3, i_addr[1:0]);
    case (i_funct3[1:0])
      2'b00:   st_dat = {4{i_wdata[7:0]}};
      2'b01:   st_dat = {2{i_wdata[15:0]}};
      default: st_dat = i_wdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          timeout;

  // tmo_cnt equals the number of stb-high cycles already elapsed in this bus cycle
  assign timeout = o_wb_stb & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign bus_err = o_wb_stb & (i_wb_err | timeout);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                tmo_cnt <= '0;
    else if (!o_wb_stb || bus_done) tmo_cnt <= '0;
    else                           tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign bus_err = o_wb_stb & i_wb_err;
`endif

  assign bus_done = (o_wb_stb & i_wb_ack) | bus_err;
  assign pop      = (state == WRITE) & bus_done;

  always_ff @(posedge i_clk) begin
    if (push) begin
      adr_mem[wr_ptr] <= {i_addr[31:2], 2'b00};
      dat_mem[wr_ptr] <= st_dat;
      sel_mem[wr_ptr] <= st_sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      load_busy <= 1'b0;
      ld_addr   <= '0;
      ld_f3     <= '0;
      o_rdata   <= '0;
      o_rvalid  <= 1'b0;
      o_err     <= 1'b0;
      o_wb_adr  <= '0;
      o_wb_dat  <= '0;
      o_wb_we   <= 1'b0;
      o_wb_sel  <= '0;
      o_wb_stb  <= 1'b0;
      o_wb_cyc  <= 1'b0;
    end else begin
      o_rvalid <= 1'b0;
      o_err    <= err_accept | bus_err;
      count    <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load_start) begin
        load_busy <= 1'b1;
        ld_addr   <= i_addr;
        ld_f3     <= i_funct3;
      end
      case (state)
        IDLE: begin
          if (count != '0)                  state <= WRITE;
          else if (load_busy || load_start) state <= READ;
        end
        WRITE: begin
          if (!o_wb_stb) begin
            o_wb_stb <= 1'b1;
            o_wb_cyc <= 1'b1;
            o_wb_we  <= 1'b1;
            o_wb_adr <= adr_mem[rd_ptr];
            o_wb_dat <= dat_mem[rd_ptr];
            o_wb_sel <= sel_mem[rd_ptr];
          end else if (bus_done) begin
            o_wb_stb <= 1'b0;
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
            rd_ptr   <= rd_ptr + 1'b1;
            if (count == (PW+1)'(1)) state <= IDLE;
          end
        end
        READ: begin
          if (!o_wb_stb) begin
            o_wb_stb <= 1'b1;
            o_wb_cyc <= 1'b1;
            o_wb_we  <= 1'b0;
            o_wb_adr <= {ld_addr[31:2], 2'b00};
            o_wb_dat <= '0;
            o_wb_sel <= lane_sel(ld_f3, ld_addr[1:0]);
          end else if (bus_done) begin
            o_wb_stb  <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_rvalid  <= 1'b1;
            o_rdata   <= bus_err ? 32'h0 : load_ext(ld_f3, ld_addr[1:0], i_wb_dat);
            load_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_wb_lsu.sv
// Scoreboard bench for rv_wb_lsu: stimulus pushes expected bus writes / load results,
// a negedge monitor pops and compares. Timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_rv_wb_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  f3 = '0;
  logic        stall, rvalid, err, tcm_hit;
  logic [31:0] rdata, wb_adr, wb_dat;
  logic        wb_we, wb_stb, wb_cyc;
  logic [3:0]  wb_sel;
  logic        ack_en = 1'b0, err_en = 1'b0;
  logic [31:0] rd_data = '0;
  logic        wb_ack, wb_err;

  assign wb_ack = wb_stb & ack_en;
  assign wb_err = wb_stb & err_en;

  rv_wb_lsu #(.WBUF_DEPTH(4), .SEL_MSB(31), .SEL_LSB(28), .TCM_SEL(4'h0), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .i_funct3(f3), .o_stall(stall), .o_rdata(rdata), .o_rvalid(rvalid), .o_err(err),
    .o_tcm_hit(tcm_hit), .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .i_wb_dat(rd_data),
    .o_wb_we(wb_we), .o_wb_sel(wb_sel), .o_wb_stb(wb_stb), .o_wb_cyc(wb_cyc),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; } wr_t;
  typedef struct { logic [31:0] data; logic err; } rd_t;
  wr_t exp_wr[$];
  rd_t exp_rd[$];
  int total = 0, bad = 0;
  logic rd_stb_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every completed bus write and every load result against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_stb && wb_we && (wb_ack || wb_err)) begin
        if (exp_wr.size() == 0) check("unexpected_write", wb_adr, 32'hxxxx_xxxx);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_adr", wb_adr, e.adr);
          check("wr_dat", wb_dat, e.dat);
          check("wr_sel", {28'h0, wb_sel}, {28'h0, e.sel});
        end
      end
      if (wb_stb && !wb_we && !rd_stb_seen)
        check("ld_after_writes", exp_wr.size(), 0);
      if (rvalid) begin
        if (exp_rd.size() == 0) check("unexpected_rvalid", rdata, 32'hxxxx_xxxx);
        else begin
          rd_t r;
          r = exp_rd.pop_front();
          check("ld_rdata", rdata, r.data);
          check("ld_err", {31'h0, err}, {31'h0, r.err});
        end
      end
    end
    rd_stb_seen = wb_stb & ~wb_we;
  end

  // Present one request from posedge+1 until it is no longer stalled; returns stall cycles.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] fn, input int ack_after, output int cycles);
    req = 1'b1; we = w; addr = a; wdata = d; f3 = fn;
    cycles = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cycles++;
      if (cycles > 200) begin
        check("stall_bound", 32'(cycles), 32'd0);
        break;
      end
      @(posedge clk); #1;
      if (cycles == ack_after) ack_en = 1'b1;
    end
    @(posedge clk); #1;
    req = 1'b0;
    $display("txn we=%0d addr=%h f3=%0d wdata=%h stall_cycles=%0d", w, a, fn, d, cycles);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_wr.size() == 0 && !wb_cyc) break;
      n++;
      if (n > 300) begin
        check("drain_bound", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] outs_or();
    return {31'h0, |{stall, rdata, rvalid, err, wb_adr, wb_dat, wb_we, wb_sel, wb_stb, wb_cyc}};
  endfunction

  initial begin
    int c;
    logic seen;
    #1;
    check("reset_outputs", outs_or(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stores: lane placement and no stall with an empty FIFO
    ack_en = 1'b1;
    exp_wr.push_back('{32'h1000_0000, 32'hA5A5_A5A5, 4'b1000});
    issue(1'b1, 32'h1000_0003, 32'h0000_00A5, 3'b000, -1, c);
    check("sb_stall", 32'(c), 32'd0);
    exp_wr.push_back('{32'h1000_0000, 32'h1234_1234, 4'b1100});
    issue(1'b1, 32'h1000_0002, 32'h0000_1234, 3'b001, -1, c);
    exp_wr.push_back('{32'h1000_0008, 32'hCAFE_F00D, 4'b1111});
    issue(1'b1, 32'h1000_0008, 32'hCAFE_F00D, 3'b010, -1, c);
    wait_drain();

    // Loads: extension, lane select and 3-cycle latency with immediate ack
    rd_data = 32'h8001_0000;
    exp_rd.push_back('{32'hFFFF_8001, 1'b0});
    issue(1'b0, 32'h1000_0002, 32'h0, 3'b001, -1, c);
    check("lh_latency", 32'(c), 32'd3);
    exp_rd.push_back('{32'h0000_8001, 1'b0});
    issue(1'b0, 32'h1000_0002, 32'h0, 3'b101, -1, c);
    check("lhu_latency", 32'(c), 32'd3);
    exp_rd.push_back('{32'hFFFF_FF80, 1'b0});
    issue(1'b0, 32'h1000_0003, 32'h0, 3'b000, -1, c);
    rd_data = 32'h1234_5678;
    exp_rd.push_back('{32'h0000_0056, 1'b0});
    issue(1'b0, 32'h1000_0001, 32'h0, 3'b100, -1, c);
    exp_rd.push_back('{32'h1234_5678, 1'b0});
    issue(1'b0, 32'h1000_0004, 32'h0, 3'b010, -1, c);

    // TCM access: combinational hit, no stall, no bus cycle
    req = 1'b1; we = 1'b1; addr = 32'h0000_0010; wdata = 32'h1; f3 = 3'b010;
    @(negedge clk);
    check("tcm_hit", {31'h0, tcm_hit}, 32'd1);
    check("tcm_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1; req = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= wb_cyc; end
    check("tcm_no_cyc", {31'h0, seen}, 32'd0);
    @(posedge clk); #1;

    // FIFO full: 5th store stalls until one ack frees a slot
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++)
      exp_wr.push_back('{32'h1000_0100 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'b1111});
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h1000_0100 + 32'(4 * i), 32'h1111_0000 + 32'(i), 3'b010, -1, c);
      check("fill_stall", 32'(c), 32'd0);
    end
    issue(1'b1, 32'h1000_0110, 32'h1111_0004, 3'b010, 2, c);
    check("full_stall", 32'(c), 32'd3);
    wait_drain();

    // Load waits behind two posted writes
    ack_en = 1'b0;
    exp_wr.push_back('{32'h1000_0200, 32'h0000_0001, 4'b1111});
    exp_wr.push_back('{32'h1000_0204, 32'h0000_0002, 4'b1111});
    issue(1'b1, 32'h1000_0200, 32'h1, 3'b010, -1, c);
    issue(1'b1, 32'h1000_0204, 32'h2, 3'b010, -1, c);
    rd_data = 32'h0BAD_BEEF;
    exp_rd.push_back('{32'h0BAD_BEEF, 1'b0});
    issue(1'b0, 32'h1000_0208, 32'h0, 3'b010, 3, c);
    check("order_queue_empty", exp_wr.size(), 0);

    // Misaligned word load: err pulse, no bus cycle
    issue(1'b0, 32'h1000_0002, 32'h0, 3'b010, -1, c);
    check("mis_stall", 32'(c), 32'd0);
    @(negedge clk);
    check("mis_err", {31'h0, err}, 32'd1);
    check("mis_no_cyc", {31'h0, wb_cyc}, 32'd0);
    @(negedge clk);
    check("mis_err_pulse", {31'h0, err}, 32'd0);
    @(posedge clk); #1;
    issue(1'b1, 32'h1000_0001, 32'h0, 3'b001, -1, c);
    @(negedge clk);
    check("mis_sh_err", {31'h0, err}, 32'd1);
    @(posedge clk); #1;

    // Bus error on a read
    ack_en = 1'b0; err_en = 1'b1; rd_data = 32'hFFFF_FFFF;
    exp_rd.push_back('{32'h0, 1'b1});
    issue(1'b0, 32'h1000_0004, 32'h0, 3'b010, -1, c);
    check("berr_latency", 32'(c), 32'd3);
    err_en = 1'b0;

`ifdef LSU_TIMEOUT_EN
    // Timeout: stb held exactly 8 cycles then ends as an error
    ack_en = 1'b0;
    exp_rd.push_back('{32'h0, 1'b1});
    req = 1'b1; we = 1'b0; addr = 32'h1000_0008; f3 = 3'b010;
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wb_stb) c++;
      if (!stall) break;
    end
    @(posedge clk); #1; req = 1'b0;
    check("timeout_stb_cycles", 32'(c), 32'd8);
`endif

    // Reset with buffered writes: everything discarded
    ack_en = 1'b0;
    issue(1'b1, 32'h1000_0300, 32'h3, 3'b010, -1, c);
    issue(1'b1, 32'h1000_0304, 32'h4, 3'b010, -1, c);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; #1;
    check("rst_wr_outputs", outs_or(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ack_en = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= wb_cyc; end
    check("rst_fifo_empty", {31'h0, seen}, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a read
    ack_en = 1'b0;
    req = 1'b1; we = 1'b0; addr = 32'h1000_000C; f3 = 3'b010;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_stb) begin seen = 1'b1; break; end
    end
    check("rst_rd_stb", {31'h0, seen}, 32'd1);
    rst_n = 1'b0; #1;
    check("rst_rd_outputs", outs_or(), 32'd0);
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ack_en = 1'b1; rd_data = 32'h0000_00FF;
    exp_rd.push_back('{32'hFFFF_FFFF, 1'b0});
    issue(1'b0, 32'h1000_0000, 32'h0, 3'b000, -1, c);
    check("post_rst_latency", 32'(c), 32'd3);

    repeat (3) @(negedge clk);
    check("end_wr_queue", exp_wr.size(), 0);
    check("end_rd_queue", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
